// File: rtl/draw_menu_char.sv
// Text-menu overlay: draws a COLS x ROWS glyph box and highlights the selected item row.
// Optional blinking highlight enabled by defining MENU_BLINK_EN.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module draw_menu_char #(
   parameter int          XPOS            = 100,
   parameter int          YPOS            = 250,
   parameter int          COLS            = 16,
   parameter int          ROWS            = 16,
   parameter int          ITEM_COUNT      = 2,
   parameter int          FIRST_ITEM_ROW  = 0,
   parameter int          ITEM_ROW_STRIDE = 6,
   parameter int          WRAP            = 1,
   parameter logic [11:0] TEXT_COLOR      = 12'hfff,
   parameter logic [11:0] SEL_COLOR       = 12'hff0,
   parameter int          BLINK_FRAMES    = 30,
   localparam int         IDX_W           = (ITEM_COUNT > 1) ? $clog2(ITEM_COUNT) : 1
) (
   input  logic                     pclk,
   input  logic                     rst,
   input  logic [`VGA_BUS_SIZE-1:0] vga_in,
   input  logic [7:0]               char_pixels,
   input  logic                     enable,
   input  logic                     btn_up,
   input  logic                     btn_down,
   input  logic                     btn_ok,
   output logic [7:0]               char_xy,
   output logic [3:0]               char_line,
   output logic [IDX_W-1:0]         sel_idx,
   output logic                     sel_valid,
   output logic [`VGA_BUS_SIZE-1:0] vga_out
);

   // Bus layout: {vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]}
   logic [10:0]      w_hcount, w_vcount, w_hc, w_vc;
   logic             w_vsync, w_in_box, w_row_match, w_hl_on, w_vs_rise;
   logic             w_up_e, w_dn_e, w_ok_e, w_move_up, w_move_dn, w_lit;
   logic [IDX_W-1:0] w_sel_nxt;

   logic             r_up_prev, r_dn_prev, r_ok_prev, r_vs_prev;
   logic [IDX_W-1:0] r_sel_idx, r_disp_idx;
   logic             r_sel_valid;

   logic [`VGA_BUS_SIZE-1:0] r_vga_d1, r_vga_d2, r_vga_out;
   logic             r_inbox_d1, r_inbox_d2, r_hl_d1, r_hl_d2, r_en_d1, r_en_d2;
   logic [2:0]       r_px_d1, r_px_d2;
   logic [7:0]       r_char_xy;
   logic [3:0]       r_char_line;

   always_comb begin
      w_hcount  = vga_in[24:14];
      w_vcount  = vga_in[37:27];
      w_vsync   = vga_in[26];
      w_hc      = w_hcount - 11'(XPOS);
      w_vc      = w_vcount - 11'(YPOS);
      w_in_box  = (32'(w_hcount) >= 32'(XPOS)) && (32'(w_hcount) < 32'(XPOS + 8*COLS)) &&
                  (32'(w_vcount) >= 32'(YPOS)) && (32'(w_vcount) < 32'(YPOS + 16*ROWS));
      w_row_match = (32'(w_vc[7:4]) ==
                     32'(FIRST_ITEM_ROW) + 32'(r_disp_idx) * 32'(ITEM_ROW_STRIDE));
      w_vs_rise = w_vsync & ~r_vs_prev;
      w_up_e    = enable & btn_up   & ~r_up_prev;
      w_dn_e    = enable & btn_down & ~r_dn_prev;
      w_ok_e    = enable & btn_ok   & ~r_ok_prev;
      w_move_up = w_up_e & ~w_dn_e;
      w_move_dn = w_dn_e & ~w_up_e;
   end

   always_comb begin
      w_sel_nxt = r_sel_idx;
      if (w_move_up) begin
         if (r_sel_idx == '0)
            w_sel_nxt = (WRAP != 0) ? IDX_W'(ITEM_COUNT - 1) : '0;
         else
            w_sel_nxt = r_sel_idx - 1'b1;
      end else if (w_move_dn) begin
         if (32'(r_sel_idx) >= 32'(ITEM_COUNT - 1))
            w_sel_nxt = (WRAP != 0) ? '0 : r_sel_idx;
         else
            w_sel_nxt = r_sel_idx + 1'b1;
      end
   end

`ifdef MENU_BLINK_EN
   logic [15:0] r_blink_cnt;
   logic        r_blink_on, r_force_on;

   // A move restarts the blink cycle; the ON phase is forced at the frame commit.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
         r_force_on  <= 1'b0;
      end else if (w_sel_nxt != r_sel_idx) begin
         r_blink_cnt <= '0;
         r_force_on  <= 1'b1;
      end else if (w_vs_rise) begin
         if (r_force_on) begin
            r_blink_on  <= 1'b1;
            r_blink_cnt <= '0;
            r_force_on  <= 1'b0;
         end else if (32'(r_blink_cnt) >= 32'(BLINK_FRAMES - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 16'd1;
         end
      end
   end

   assign w_hl_on = r_blink_on;
`else
   assign w_hl_on = 1'b1;
`endif

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_up_prev   <= 1'b0;
         r_dn_prev   <= 1'b0;
         r_ok_prev   <= 1'b0;
         r_vs_prev   <= 1'b0;
         r_sel_idx   <= '0;
         r_disp_idx  <= '0;
         r_sel_valid <= 1'b0;
      end else begin
         r_up_prev   <= btn_up;
         r_dn_prev   <= btn_down;
         r_ok_prev   <= btn_ok;
         r_vs_prev   <= w_vsync;
         r_sel_idx   <= w_sel_nxt;
         r_sel_valid <= w_ok_e;
         // Highlight follows the cursor only at frame start to avoid tearing.
         if (w_vs_rise)
            r_disp_idx <= r_sel_idx;
      end
   end

   always_comb begin
      w_lit = r_en_d2 & ~r_vga_d2[12] & ~r_vga_d2[25] & r_inbox_d2 &
              char_pixels[3'd7 - r_px_d2];
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_vga_d1    <= '0;
         r_vga_d2    <= '0;
         r_vga_out   <= '0;
         r_inbox_d1  <= 1'b0;
         r_inbox_d2  <= 1'b0;
         r_hl_d1     <= 1'b0;
         r_hl_d2     <= 1'b0;
         r_en_d1     <= 1'b0;
         r_en_d2     <= 1'b0;
         r_px_d1     <= '0;
         r_px_d2     <= '0;
         r_char_xy   <= '0;
         r_char_line <= '0;
      end else begin
         r_vga_d1    <= vga_in;
         r_inbox_d1  <= w_in_box;
         r_hl_d1     <= w_row_match & w_hl_on;
         r_en_d1     <= enable;
         r_px_d1     <= w_hc[2:0];
         r_char_xy   <= w_in_box ? {w_vc[7:4], w_hc[6:3]} : 8'h00;
         r_char_line <= w_in_box ? w_vc[3:0] : 4'h0;
         r_vga_d2    <= r_vga_d1;
         r_inbox_d2  <= r_inbox_d1;
         r_hl_d2     <= r_hl_d1;
         r_en_d2     <= r_en_d1;
         r_px_d2     <= r_px_d1;
         r_vga_out   <= {r_vga_d2[37:12],
                         w_lit ? (r_hl_d2 ? SEL_COLOR : TEXT_COLOR) : r_vga_d2[11:0]};
      end
   end

   assign char_xy   = r_char_xy;
   assign char_line = r_char_line;
   assign sel_idx   = r_sel_idx;
   assign sel_valid = r_sel_valid;
   assign vga_out   = r_vga_out;

endmodule

// File: tb/tb_draw_menu_char.sv
// Bench for draw_menu_char: coordinate-level pixel model, cursor model, directed vectors.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_draw_menu_char;
   logic        clk = 1'b0;
   logic        rst;
   logic [37:0] vga_in;
   logic [7:0]  char_pixels, rom_q;
   logic        en, b_up, b_dn, b_ok;
   logic [7:0]  char_xy, s_xy;
   logic [3:0]  char_line, s_line;
   logic [1:0]  sel_idx, s_sel;
   logic        sel_valid, s_valid;
   logic [37:0] vga_out, s_out;

   logic        vs_lvl = 1'b0, hs_lvl = 1'b0, hb_lvl = 1'b0;
   logic        rom_all_ones = 1'b0;
   int          total = 0, bad = 0;
   logic [37:0] exp_q[$];

   int          m_sel, m_sel_sat, m_disp;
   logic        m_up, m_dn, m_ok, m_vs, m_valid;
   logic [7:0]  m_xy;
   logic [3:0]  m_line;

   always #5 clk = ~clk;

   draw_menu_char #(.ITEM_COUNT(3), .WRAP(1)) dut (
      .pclk(clk), .rst(rst), .vga_in(vga_in), .char_pixels(char_pixels), .enable(en),
      .btn_up(b_up), .btn_down(b_dn), .btn_ok(b_ok), .char_xy(char_xy),
      .char_line(char_line), .sel_idx(sel_idx), .sel_valid(sel_valid), .vga_out(vga_out));

   draw_menu_char #(.ITEM_COUNT(3), .WRAP(0)) dut_sat (
      .pclk(clk), .rst(rst), .vga_in(vga_in), .char_pixels(8'h00), .enable(en),
      .btn_up(b_up), .btn_down(b_dn), .btn_ok(b_ok), .char_xy(s_xy),
      .char_line(s_line), .sel_idx(s_sel), .sel_valid(s_valid), .vga_out(s_out));

   // Glyph bit 7 is always lit; char 0 line 0 is exactly 8'h80.
   function automatic logic [7:0] font(logic [7:0] xy, logic [3:0] line);
      if (rom_all_ones) return 8'hff;
      return 8'h80 | ((xy ^ {line, line}) & 8'h7f);
   endfunction

   always @(posedge clk) rom_q <= font(char_xy, char_line);
   assign char_pixels = rom_q;

   function automatic logic [37:0] pack(int h, int v, logic [11:0] rgb);
      return {11'(v), vs_lvl, 1'b0, 11'(h), hs_lvl, hb_lvl, rgb};
   endfunction

   function automatic logic [37:0] model_out(logic [37:0] in, logic e, int disp);
      int h, v, row, col, line;
      logic [11:0] rgb;
      logic [7:0]  g;
      h = int'(in[24:14]);
      v = int'(in[37:27]);
      rgb = in[11:0];
      if (e && !in[12] && !in[25] && h >= 100 && h < 228 && v >= 250 && v < 506) begin
         row  = (v - 250) / 16;
         col  = (h - 100) / 8;
         line = (v - 250) % 16;
         g    = font({row[3:0], col[3:0]}, line[3:0]);
         if (g[7 - ((h - 100) % 8)]) rgb = (row == disp * 6) ? 12'hff0 : 12'hfff;
      end
      return {in[37:12], rgb};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: updates on the same edges the design samples.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_sel = 0; m_sel_sat = 0; m_disp = 0;
         m_up = 0; m_dn = 0; m_ok = 0; m_vs = 0; m_valid = 0;
         m_xy = 0; m_line = 0;
         exp_q.delete();
      end else begin
         int h, v;
         logic ue, de;
         h = int'(vga_in[24:14]);
         v = int'(vga_in[37:27]);
         exp_q.push_back(model_out(vga_in, en, m_disp));
         if (h >= 100 && h < 228 && v >= 250 && v < 506) begin
            m_xy   = {4'((v - 250) / 16), 4'((h - 100) / 8)};
            m_line = 4'((v - 250) % 16);
         end else begin
            m_xy = 0; m_line = 0;
         end
         ue = en && b_up && !m_up;
         de = en && b_dn && !m_dn;
         m_valid = en && b_ok && !m_ok;
         if (vga_in[26] && !m_vs) m_disp = m_sel;
         if (ue && !de) begin
            m_sel = (m_sel + 2) % 3;
            if (m_sel_sat > 0) m_sel_sat = m_sel_sat - 1;
         end
         if (de && !ue) begin
            m_sel = (m_sel + 1) % 3;
            if (m_sel_sat < 2) m_sel_sat = m_sel_sat + 1;
         end
         m_up = b_up; m_dn = b_dn; m_ok = b_ok; m_vs = vga_in[26];
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("sel_idx", 64'(sel_idx), 64'(m_sel));
         chk("sel_idx_sat", 64'(s_sel), 64'(m_sel_sat));
         chk("sel_valid", 64'(sel_valid), 64'(m_valid));
         chk("char_xy", 64'(char_xy), 64'(m_xy));
         chk("char_line", 64'(char_line), 64'(m_line));
         if (exp_q.size() >= 3) chk("vga_out", 64'(vga_out), 64'(exp_q.pop_front()));
      end
   end

   task automatic drive(int h, int v, logic [11:0] rgb);
      vga_in = pack(h, v, rgb);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         drive(0, 0, 12'h000);
      end
   endtask

   task automatic probe(int h, int v, logic [11:0] rgb, output logic [37:0] inbus,
                        output logic [37:0] got);
      @(negedge clk);
      drive(h, v, rgb);
      inbus = vga_in;
      @(negedge clk);
      drive(0, 0, 12'h000);
      @(negedge clk);
      @(negedge clk);
      got = vga_out;
   endtask

   task automatic press(logic u, logic d, logic o);
      @(negedge clk);
      b_up = u; b_dn = d; b_ok = o;
      @(negedge clk);
      b_up = 0; b_dn = 0; b_ok = 0;
   endtask

   initial begin
      logic [37:0] ib, got;
      int pulses, k;
      rst = 1; en = 1; b_up = 0; b_dn = 0; b_ok = 0;
      vga_in = '0;
      #1;
      chk("reset_vga_out", 64'(vga_out), 64'h0);
      chk("reset_sel_idx", 64'(sel_idx), 64'h0);
      chk("reset_sel_valid", 64'(sel_valid), 64'h0);
      idle(3);
      @(negedge clk);
      rst = 0;
      idle(4);

      // Glyph draw at the box origin.
      @(negedge clk); drive(100, 250, 12'h0aa);
      @(negedge clk); chk("glyph_xy", 64'(char_xy), 64'h00); drive(101, 250, 12'h0bb);
      @(negedge clk); drive(0, 0, 12'h000);
      @(negedge clk); chk("glyph_lit", 64'(vga_out[11:0]), 64'hff0);
      @(negedge clk); chk("glyph_unlit", 64'(vga_out[11:0]), 64'h0bb);

      @(negedge clk); drive(126, 351, 12'h000);
      @(negedge clk); chk("addr_xy", 64'(char_xy), 64'h63);
      chk("addr_line", 64'(char_line), 64'h5);
      idle(3);

      // Navigation with wrap / saturate.
      press(1, 0, 0);
      chk("nav_up_wrap", 64'(sel_idx), 64'd2);
      chk("nav_up_sat", 64'(s_sel), 64'd0);
      probe(100, 442, 12'h001, ib, got);
      chk("hl_before_vsync_row12", 64'(got[11:0]), 64'hfff);
      probe(100, 250, 12'h001, ib, got);
      chk("hl_before_vsync_row0", 64'(got[11:0]), 64'hff0);
      vs_lvl = 1; idle(2); vs_lvl = 0; idle(2);
      probe(100, 442, 12'h001, ib, got);
      chk("hl_after_vsync_row12", 64'(got[11:0]), 64'hff0);
      probe(100, 250, 12'h001, ib, got);
      chk("hl_after_vsync_row0", 64'(got[11:0]), 64'hfff);

      press(1, 1, 0);
      chk("nav_both", 64'(sel_idx), 64'd2);
      press(0, 1, 0);
      chk("nav_down_wrap", 64'(sel_idx), 64'd0);
      press(0, 1, 0);
      press(0, 1, 0);
      chk("nav_down_sat_top", 64'(s_sel), 64'd2);
      press(1, 0, 0);
      chk("nav_to_one", 64'(sel_idx), 64'd1);

      // Confirm: one pulse for a held button.
      pulses = 0;
      @(negedge clk); b_ok = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (sel_valid) pulses++;
      end
      b_ok = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (sel_valid) pulses++;
      end
      chk("confirm_pulses", 64'(pulses), 64'd1);
      chk("confirm_idx", 64'(sel_idx), 64'd1);

      // Disabled: buttons ignored, overlay transparent.
      @(negedge clk); en = 0;
      press(1, 0, 1);
      chk("disabled_idx", 64'(sel_idx), 64'd1);
      rom_all_ones = 1;
      hs_lvl = 1;
      probe(130, 300, 12'h123, ib, got);
      chk("passthrough_bus", 64'(got), 64'(ib));
      hs_lvl = 0;
      idle(2);
      rom_all_ones = 0;
      @(negedge clk); en = 1;
      hb_lvl = 1;
      probe(100, 250, 12'h456, ib, got);
      chk("hblank_passthrough", 64'(got[11:0]), 64'h456);
      hb_lvl = 0;
      idle(2);

      // Reset mid-frame with active pixels.
      @(negedge clk); drive(108, 260, 12'h777);
      @(negedge clk); drive(100, 250, 12'h777);
      #2 rst = 1;
      #1;
      chk("midreset_vga_out", 64'(vga_out), 64'h0);
      chk("midreset_sel_idx", 64'(sel_idx), 64'h0);
      vga_in = '0;
      idle(2);
      @(negedge clk); rst = 0;
      @(negedge clk); drive(50, 10, 12'habc);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(0, 0, 12'h000);
         if (vga_out[11:0] == 12'habc && k == 0) k = i + 1;
      end
      chk("latency_after_reset", 64'(k), 64'd3);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
